// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and elaboration helpers for the multi-channel tick generator
package tick_gen_pkg;
  localparam int DIV_W_DEF = 26;
  localparam int CH_IDX_W = 3;
  localparam int MAX_CH = 1 << CH_IDX_W;
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    while ((longint'(1) << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divider channel; a pending divisor is swapped in only at a wrap, clear or while idle
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEF = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
  output logic             pend,
  output logic             tick,
  output logic             toggle
);
  logic [DIV_W-1:0] cnt, div, pdiv;
  logic run, wrap, commit;
  assign run = en & (div != '0);
  assign wrap = run & (cnt == div - 1'b1);
  // div of 0 or 1 has no period to protect, so it commits immediately regardless of en
  assign commit = pend & (sync_clr | wrap | (div <= DIV_W'(1)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      div <= DEF;
      pdiv <= '0;
      pend <= 1'b0;
      tick <= 1'b0;
      toggle <= 1'b0;
    end else begin
      cnt <= (sync_clr | wrap) ? '0 : run ? cnt + 1'b1 : cnt;
      tick <= ~sync_clr & wrap;
      toggle <= ~sync_clr & (toggle ^ wrap);
      if (we) begin
        pdiv <= wdiv;
        pend <= 1'b1;
      end else if (commit) begin
        div <= pdiv;
        pend <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH programmable tick/toggle channels with a valid/ready divisor update port
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int NUM_CH = 3,
  parameter int DIV_W = DIV_W_DEF,
  parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV = {26'd50000000, 26'd25000000, 26'd50000}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync_clr,
  input  logic                cfg_valid,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                cfg_ready,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   toggle
);
  if (clog2(longint'(CLK_HZ) + 1) > DIV_W) begin : g_bad_w
    $error("DIV_W too narrow for CLK_HZ");
  end
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_n
    $error("NUM_CH out of range");
  end
  logic [NUM_CH-1:0] pend;
  logic [MAX_CH-1:0] pend_x;
  assign pend_x = MAX_CH'(pend);
  assign cfg_ready = ({1'b0, cfg_ch} < (CH_IDX_W + 1)'(NUM_CH)) & ~pend_x[cfg_ch];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(.DIV_W(DIV_W), .DEF(DEF_DIV[i*DIV_W +: DIV_W])) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .sync_clr(sync_clr),
      .we(cfg_valid & cfg_ready & (cfg_ch == CH_IDX_W'(i))),
      .wdiv(cfg_div),
      .pend(pend[i]),
      .tick(tick[i]),
      .toggle(toggle[i])
    );
  end
endmodule
